// File: rtl/adc_frame_packer.sv
// Purpose: packs AD7606 per-channel samples into framed byte packets through a two-bank ping-pong buffer.
// Latency: HDR0 is presented two cycles after the last sample strobe of a frame when TX is idle.
// Backpressure: byte_o/byte_valid_o hold while !byte_ready_i; a completed frame is dropped when both banks are full.
//
// Frame: HDR0 HDR1 SEQ [TS_HI TS_LO] {sample hi, sample lo} x NUM_CH CSUM.
// CSUM is the mod-256 sum of every byte after HDR1.
// Optional timestamp fields are built only when ADC_PACK_TSTAMP_EN is defined.
// Ports:
//   fpga_clk_i, reset_i                    clock and async active-high reset
//   data_i, sync_i, data_rd_ready_i        sample stream from the ADC controller
//   byte_o, byte_valid_o, byte_ready_i     byte stream toward the transmit stage
//   frame_drop_o, sync_err_o, drop_cnt_o   status pulses and saturating drop count
module adc_frame_packer #(
  parameter int         NUM_CH = 8,
  parameter logic [7:0] HDR0   = 8'hA5,
  parameter logic [7:0] HDR1   = 8'h5A
) (
  input  logic        fpga_clk_i,
  input  logic        reset_i,
  input  logic [15:0] data_i,
  input  logic        sync_i,
  input  logic        data_rd_ready_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        frame_drop_o,
  output logic        sync_err_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int             IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0]  ILAST = IW'(NUM_CH - 1);
  localparam logic [IW:0]    BLAST = (IW+1)'(2*NUM_CH - 1);

  typedef enum logic [1:0] {CAP_WAIT, CAP_FILL, CAP_DONE} cap_t;
  typedef enum logic [2:0] {TX_IDLE, TX_HDR0, TX_HDR1, TX_SEQ,
                            TX_TS_HI, TX_TS_LO, TX_DATA, TX_CSUM} tx_t;

  logic [15:0]   mem [2][NUM_CH];
  logic [1:0]    full;
  logic [7:0]    bank_seq [2];
  logic          wr_bank, rd_bank;
  logic [7:0]    seq;

  cap_t          cap_st, cap_n;
  logic [IW-1:0] idx, idx_n, w_idx;
  logic          lost, lost_n;
  logic          wr_en, complete, keep, sync_err_n;

  tx_t           tx_st, tx_n;
  logic [7:0]    byte_n, csum, csum_n, dbyte;
  logic          vld_n, hs, rel;
  logic [IW:0]   bcnt, bcnt_n, bsel;
  logic [15:0]   smp;

`ifdef ADC_PACK_TSTAMP_EN
  logic [15:0]   ts_cnt, cap_ts, ts_frame;
  logic [15:0]   bank_ts [2];
`endif

  // Capture: any sample with sync_i=1 (re)starts a frame at index 0.
  // "lost" records that some sample of the frame arrived while the owned bank was
  // still full (only possible when both banks are full); such a frame cannot be
  // kept even if the bank frees up before completion, since its early samples were
  // never written.
  always_comb begin
    cap_n      = cap_st;
    idx_n      = idx;
    lost_n     = lost;
    w_idx      = idx;
    wr_en      = 1'b0;
    complete   = 1'b0;
    sync_err_n = 1'b0;
    if (data_rd_ready_i) begin
      if (sync_i) begin
        sync_err_n = (cap_st == CAP_FILL);
        wr_en      = 1'b1;
        w_idx      = '0;
        lost_n     = full[wr_bank];
      end else if (cap_st == CAP_FILL) begin
        wr_en  = 1'b1;
        lost_n = lost | full[wr_bank];
      end else if (cap_st == CAP_DONE) begin
        sync_err_n = 1'b1;
        cap_n      = CAP_WAIT;
      end
      if (wr_en) begin
        if (w_idx == ILAST) begin
          complete = 1'b1;
          cap_n    = CAP_DONE;
        end else begin
          cap_n = CAP_FILL;
          idx_n = w_idx + 1'b1;
        end
      end
    end
  end

  // full[wr_bank] is registered, so a bank released this cycle is seen free only next cycle.
  assign keep = complete & ~lost_n;
  assign hs   = byte_valid_o & byte_ready_i;

  // Data byte to load next: first byte on entry to DATA, else the following one.
  assign bsel  = (tx_st == TX_DATA) ? bcnt + 1'b1 : '0;
  assign smp   = mem[rd_bank][bsel[IW:1]];
  assign dbyte = bsel[0] ? smp[7:0] : smp[15:8];

  // TX: the state names the byte currently held in byte_o. Checksum accumulates
  // each byte as it is loaded, so at CSUM it already covers SEQ..last data byte.
  always_comb begin
    tx_n   = tx_st;
    byte_n = byte_o;
    vld_n  = byte_valid_o;
    bcnt_n = bcnt;
    csum_n = csum;
    rel    = 1'b0;
    case (tx_st)
      TX_IDLE: if (full[rd_bank]) begin
        tx_n   = TX_HDR0;
        byte_n = HDR0;
        vld_n  = 1'b1;
      end
      TX_HDR0: if (hs) begin
        tx_n   = TX_HDR1;
        byte_n = HDR1;
      end
      TX_HDR1: if (hs) begin
        tx_n   = TX_SEQ;
        byte_n = bank_seq[rd_bank];
        csum_n = bank_seq[rd_bank];
      end
`ifdef ADC_PACK_TSTAMP_EN
      TX_SEQ: if (hs) begin
        tx_n   = TX_TS_HI;
        byte_n = bank_ts[rd_bank][15:8];
        csum_n = csum + bank_ts[rd_bank][15:8];
      end
      TX_TS_HI: if (hs) begin
        tx_n   = TX_TS_LO;
        byte_n = bank_ts[rd_bank][7:0];
        csum_n = csum + bank_ts[rd_bank][7:0];
      end
      TX_TS_LO: if (hs) begin
        tx_n   = TX_DATA;
        bcnt_n = '0;
        byte_n = dbyte;
        csum_n = csum + dbyte;
      end
`else
      TX_SEQ: if (hs) begin
        tx_n   = TX_DATA;
        bcnt_n = '0;
        byte_n = dbyte;
        csum_n = csum + dbyte;
      end
`endif
      TX_DATA: if (hs) begin
        if (bcnt == BLAST) begin
          tx_n   = TX_CSUM;
          byte_n = csum;
        end else begin
          bcnt_n = bsel;
          byte_n = dbyte;
          csum_n = csum + dbyte;
        end
      end
      TX_CSUM: if (hs) begin
        rel = 1'b1;
        // Chain straight into the other bank's frame to avoid a bubble.
        if (full[~rd_bank]) begin
          tx_n   = TX_HDR0;
          byte_n = HDR0;
        end else begin
          tx_n  = TX_IDLE;
          vld_n = 1'b0;
        end
      end
      default: tx_n = TX_IDLE;
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      cap_st       <= CAP_WAIT;
      idx          <= '0;
      lost         <= 1'b0;
      tx_st        <= TX_IDLE;
      byte_o       <= 8'd0;
      byte_valid_o <= 1'b0;
      bcnt         <= '0;
      csum         <= 8'd0;
      sync_err_o   <= 1'b0;
      frame_drop_o <= 1'b0;
    end else begin
      cap_st       <= cap_n;
      idx          <= idx_n;
      lost         <= lost_n;
      tx_st        <= tx_n;
      byte_o       <= byte_n;
      byte_valid_o <= vld_n;
      bcnt         <= bcnt_n;
      csum         <= csum_n;
      sync_err_o   <= sync_err_n;
      frame_drop_o <= complete & ~keep;
    end
  end

  // Bank ownership, sequence tagging and drop accounting. keep and rel never
  // target the same bank: keep needs it empty, rel needs it full.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      seq         <= 8'd0;
      drop_cnt_o  <= 8'd0;
      bank_seq[0] <= 8'd0;
      bank_seq[1] <= 8'd0;
    end else begin
      if (complete) begin
        seq <= seq + 8'd1;
        if (keep) begin
          full[wr_bank]     <= 1'b1;
          bank_seq[wr_bank] <= seq;
          wr_bank           <= ~wr_bank;
        end else if (drop_cnt_o != 8'hFF) begin
          drop_cnt_o <= drop_cnt_o + 8'd1;
        end
      end
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (wr_en && !full[wr_bank]) mem[wr_bank][w_idx] <= data_i;
  end

`ifdef ADC_PACK_TSTAMP_EN
  // Single-channel frames start and complete in one cycle, so bypass cap_ts.
  assign ts_frame = (data_rd_ready_i && sync_i) ? ts_cnt : cap_ts;

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_cnt     <= 16'd0;
      cap_ts     <= 16'd0;
      bank_ts[0] <= 16'd0;
      bank_ts[1] <= 16'd0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (data_rd_ready_i && sync_i) cap_ts <= ts_cnt;
      if (keep) bank_ts[wr_bank] <= ts_frame;
    end
  end
`endif

endmodule

// File: tb/tb_adc_frame_packer.sv
// Purpose: self-checking bench for adc_frame_packer against a frame-level reference model.
// Latency: inputs driven and outputs sampled once per cycle, 1 time unit after the falling edge.
// Backpressure: byte_ready_i is driven low, high and randomly to exercise holding, buffering and drops.
module tb_adc_frame_packer;
  localparam int NUM_CH = 8;
`ifdef ADC_PACK_TSTAMP_EN
  localparam int FLEN = 3 + 2 + 2*NUM_CH + 1;
`else
  localparam int FLEN = 3 + 2*NUM_CH + 1;
`endif
  localparam int HD = FLEN - 2*NUM_CH - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'd0;
  logic        sync = 1'b0, stb = 1'b0, bready = 1'b0;
  logic [7:0]  byte_o, drop_cnt_o;
  logic        byte_valid_o, frame_drop_o, sync_err_o;

  always #5 clk = ~clk;

  adc_frame_packer #(.NUM_CH(NUM_CH)) dut (
    .fpga_clk_i(clk), .reset_i(rst), .data_i(data), .sync_i(sync),
    .data_rd_ready_i(stb), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(bready), .frame_drop_o(frame_drop_o), .sync_err_o(sync_err_o),
    .drop_cnt_o(drop_cnt_o)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [7:0]  q[$];
  logic [7:0]  rx_log[$];
  logic [15:0] m_buf[$];
  int          pend, pos, m_st;   // m_st: 0 waiting for sync, 1 filling, 2 just completed
  bit          m_lost, exp_serr, exp_drop, prev_stall;
  logic [7:0]  m_seq, m_drops, prev_byte;
  logic [15:0] m_ts, tcnt;

  task automatic model_reset();
    q.delete(); m_buf.delete();
    pend = 0; pos = 0; m_st = 0; m_lost = 0;
    m_seq = 8'd0; m_drops = 8'd0; tcnt = 16'd0;
    exp_serr = 0; exp_drop = 0; prev_stall = 0; prev_byte = 8'd0;
  endtask

  task automatic push_frame();
    logic [7:0] sum;
    q.push_back(8'hA5); q.push_back(8'h5A); q.push_back(m_seq);
    sum = m_seq;
`ifdef ADC_PACK_TSTAMP_EN
    q.push_back(m_ts[15:8]); q.push_back(m_ts[7:0]);
    sum = sum + m_ts[15:8] + m_ts[7:0];
`endif
    foreach (m_buf[k]) begin
      q.push_back(m_buf[k][15:8]); q.push_back(m_buf[k][7:0]);
      sum = sum + m_buf[k][15:8] + m_buf[k][7:0];
    end
    q.push_back(sum);
  endtask

  // Evaluate one cycle: current outputs against the model, then the inputs
  // presented this cycle advance the model to the next cycle.
  task automatic eval();
    bit rel = 0, inc = 0, nserr = 0, ndrop = 0;
    chk("sync_err", sync_err_o, exp_serr);
    chk("frame_drop", frame_drop_o, exp_drop);
    chk("drop_cnt", drop_cnt_o, m_drops);
    if (prev_stall) begin
      chk("hold_vld", byte_valid_o, 1);
      chk("hold_byte", byte_o, prev_byte);
    end
    if (byte_valid_o && bready) begin
      rx_log.push_back(byte_o);
      if (q.size() == 0) chk("spurious_byte", q.size(), 1);
      else begin
        chk("byte", byte_o, q.pop_front());
        pos++;
        if (pos == FLEN) begin pos = 0; rel = 1; end
      end
    end
    if (stb) begin
      if (sync) begin
        nserr = (m_st == 1);
        m_buf.delete(); m_buf.push_back(data);
        m_lost = (pend == 2); m_ts = tcnt; m_st = 1;
      end else if (m_st == 1) begin
        m_buf.push_back(data);
        if (pend == 2) m_lost = 1;
      end else if (m_st == 2) begin
        nserr = 1; m_st = 0;
      end
      if (m_st == 1 && m_buf.size() == NUM_CH) begin
        if (!m_lost) begin push_frame(); inc = 1; end
        else begin ndrop = 1; if (m_drops != 8'hFF) m_drops++; end
        m_seq++;
        m_st = 2;
      end
    end
    pend = pend + int'(inc) - int'(rel);
    exp_serr = nserr; exp_drop = ndrop;
    prev_stall = byte_valid_o && !bready; prev_byte = byte_o;
    tcnt++;
  endtask

  task automatic tick(input logic [15:0] d, input bit s, input bit st, input bit r);
    data = d; sync = s; stb = st; bready = r;
    #1;
    eval();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) tick(16'd0, 0, 0, r);
  endtask

  task automatic send_frame(input logic [15:0] base, input bit r);
    for (int k = 0; k < NUM_CH; k++) tick(base + 16'(k), k == 0, 1, r);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((q.size() != 0 || byte_valid_o) && n < max) begin
      tick(16'd0, 0, 0, 1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", byte_valid_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; stb = 0; sync = 0; bready = 0;
    #1;
    chk("rst_vld", byte_valid_o, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_drop_cnt", drop_cnt_o, 0);
    chk("rst_serr", sync_err_o, 0);
    chk("rst_drop", frame_drop_o, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rx_log.delete();
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int rp;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reference frame and first-byte latency.
    for (int k = 0; k < NUM_CH; k++) tick(16'(16'h0101 * (k + 1)), k == 0, 1, 1);
    chk("t1_lat_n1", byte_valid_o, 0);
    tick(16'd0, 0, 0, 1);
    chk("t1_lat_n2_vld", byte_valid_o, 1);
    chk("t1_lat_n2_byte", byte_o, 8'hA5);
    drain(100);
    chk("t1_len", rx_log.size(), FLEN);
    chk("t1_seq", rx_log[2], 8'h00);
    chk("t1_d0", rx_log[HD], 8'h01);
`ifndef ADC_PACK_TSTAMP_EN
    chk("t1_csum", rx_log[FLEN-1], 8'h48);
`endif

    // Both banks full: third frame dropped, sequence keeps counting.
    do_reset();
    for (int f = 0; f < 3; f++) begin send_frame(16'(16'h1100 * (f + 1)), 0); idle(2, 0); end
    chk("t2_drop_cnt", drop_cnt_o, 1);
    drain(200);
    chk("t2_len", rx_log.size(), 2*FLEN);
    chk("t2_seq0", rx_log[2], 8'h00);
    chk("t2_seq1", rx_log[FLEN+2], 8'h01);
    send_frame(16'h7000, 1);
    drain(100);
    chk("t2_seq3", rx_log[2*FLEN+2], 8'h03);

    // Sync on 4th sample restarts the frame.
    do_reset();
    for (int k = 0; k < 3; k++) tick(16'(16'h1000 + k), k == 0, 1, 1);
    tick(16'h4321, 1, 1, 1);
    chk("t3_serr", sync_err_o, 1);
    for (int k = 1; k < NUM_CH; k++) tick(16'(16'h2000 + k), 0, 1, 1);
    drain(100);
    chk("t3_len", rx_log.size(), FLEN);
    chk("t3_first_hi", rx_log[HD], 8'h43);
    chk("t3_first_lo", rx_log[HD+1], 8'h21);

    // Samples before sync ignored; extra sample after a frame is a sync error.
    do_reset();
    for (int k = 0; k < 3; k++) tick(16'(16'hBEE0 + k), 0, 1, 1);
    send_frame(16'h3000, 1);
    tick(16'h9999, 0, 1, 1);
    chk("t4_serr", sync_err_o, 1);
    drain(100);
    chk("t4_len", rx_log.size(), FLEN);

    // Reset while a data byte is stalled.
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(16'(16'h5000 + 16'h100 * f), 0);
    idle(2, 0);
    idle(HD + 3, 1);
    tick(16'd0, 0, 0, 0);
    chk("t5_pre_vld", byte_valid_o, 1);
    do_reset();
    send_frame(16'h6000, 1);
    drain(100);
    chk("t5_seq", rx_log[2], 8'h00);

    // Drop counter saturation.
    do_reset();
    for (int f = 0; f < 258; f++) send_frame(16'($urandom), 0);
    idle(2, 0);
    chk("t7_sat", drop_cnt_o, 8'hFF);
    drain(200);

    // Randomized conversions with sync faults and varying backpressure.
    do_reset();
    for (int c = 0; c < 200; c++) begin
      int err, len;
      if (c % 50 == 0) begin
        case ((c / 50) % 4)
          0: rp = 100;
          1: rp = 70;
          2: rp = 30;
          default: rp = 5;
        endcase
      end
      err = $urandom_range(0, 9);
      len = (err == 1) ? $urandom_range(1, NUM_CH - 1) : NUM_CH;
      if (err == 0) tick(16'($urandom), 0, 1, $urandom_range(0, 99) < rp);
      for (int k = 0; k < len; k++) begin
        tick(16'($urandom), k == 0, 1, $urandom_range(0, 99) < rp);
        repeat ($urandom_range(0, 2)) tick(16'd0, 0, 0, $urandom_range(0, 99) < rp);
      end
    end
    drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
